// File: rtl/act_pkg.sv
// act_pkg: shared constants for the activation pack unit.
// Lane geometry, quantised value range and debug counter width live here so
// the clamp stage and the packer always agree on them.
package act_pkg;

   // Width of one quantised activation and lanes per packed output word.
   localparam int OUT_BITS  = 8;
   localparam int PACK_N    = 4;

   // Derived geometry.
   localparam int LANE_W    = (PACK_N > 1) ? $clog2(PACK_N) : 1;
   localparam int WORD_BITS = OUT_BITS * PACK_N;

   // Signed range of one quantised activation (127 / -128 for 8 bits).
   localparam int ACT_MAX   = (1 << (OUT_BITS - 1)) - 1;
   localparam int ACT_MIN   = -(1 << (OUT_BITS - 1));

   // Saturation event counter width; the counter sticks at all-ones.
   localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/act_sat.sv
// act_sat: combinational ReLU + clamp of one shifted accumulator value to
// signed OUT_BITS. Build option ACT_RELU_EN raises the lower clamp bound to 0.
// The sat flag always reports clipping against the full signed range, so
// ReLU zeroing of a small negative value is not flagged.
module act_sat
   import act_pkg::*;
#(
   parameter int DATA_BITS = 32
) (
   input  logic [DATA_BITS-1:0] d_in,
   output logic [OUT_BITS-1:0]  d_out,
   output logic                 sat
);

   localparam logic signed [DATA_BITS-1:0] HI     = DATA_BITS'(ACT_MAX);
   localparam logic signed [DATA_BITS-1:0] SAT_LO = DATA_BITS'(ACT_MIN);
`ifdef ACT_RELU_EN
   localparam logic signed [DATA_BITS-1:0] LO     = '0;
`else
   localparam logic signed [DATA_BITS-1:0] LO     = SAT_LO;
`endif

   logic signed [DATA_BITS-1:0] x;
   assign x = $signed(d_in);

   // Clamp to [LO, HI] and flag values outside the full signed output range.
   always_comb begin
      sat   = (x > HI) || (x < SAT_LO);
      d_out = x[OUT_BITS-1:0];
      if (x > HI) begin
         d_out = HI[OUT_BITS-1:0];
      end else if (x < LO) begin
         d_out = LO[OUT_BITS-1:0];
      end
   end

endmodule

// File: rtl/act_pack_unit.sv
// act_pack_unit: quantises shifted activations to signed 8-bit (optional ReLU
// via ACT_RELU_EN) and packs PACK_N of them per output word, lane 0 in the
// LSBs. in_last closes a partial word early; out_strb marks the written lanes.
// The output side is a single registered slot; in_ready is the only
// combinational output.
module act_pack_unit
   import act_pkg::*;
#(
   parameter int DATA_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_BITS-1:0]  in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_BITS-1:0]  out_data,
   output logic [PACK_N-1:0]     out_strb,
   output logic                  out_last,
   output logic [SAT_CNT_W-1:0]  sat_cnt
);

   logic [LANE_W-1:0]    lane_reg;
   logic [WORD_BITS-1:0] pack_reg;
   logic                 out_valid_reg;
   logic [WORD_BITS-1:0] out_data_reg;
   logic [PACK_N-1:0]    out_strb_reg;
   logic                 out_last_reg;
   logic [SAT_CNT_W-1:0] sat_cnt_reg;

   logic [OUT_BITS-1:0]  q_byte;
   logic                 q_sat;
   logic                 accept;
   logic                 last_lane;
   logic                 complete;
   logic [WORD_BITS-1:0] word_next;
   logic [PACK_N-1:0]    strb_next;

   act_sat #(
      .DATA_BITS (DATA_BITS)
   ) u_sat (
      .d_in  (in_data),
      .d_out (q_byte),
      .sat   (q_sat)
   );

   // A new element may enter whenever the output slot is free or draining.
   assign in_ready  = !out_valid_reg || out_ready;
   assign accept    = in_valid && in_ready;
   assign last_lane = (lane_reg == LANE_W'(PACK_N - 1));
   assign complete  = accept && (in_last || last_lane);

   // Word as it would look with the current byte merged into its lane;
   // lanes above the current one are still zero from the last clear.
   genvar gi;
   generate
      for (gi = 0; gi < PACK_N; gi++) begin : g_lane
         assign word_next[gi*OUT_BITS +: OUT_BITS] =
            (lane_reg == LANE_W'(gi)) ? q_byte : pack_reg[gi*OUT_BITS +: OUT_BITS];
         assign strb_next[gi] = (LANE_W'(gi) <= lane_reg);
      end
   endgenerate

   // Lane counter and pack register: fill lanes, restart after each word.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_reg <= '0;
         pack_reg <= '0;
      end else if (accept) begin
         if (complete) begin
            lane_reg <= '0;
            pack_reg <= '0;
         end else begin
            lane_reg <= lane_reg + LANE_W'(1);
            pack_reg <= word_next;
         end
      end
   end

   // Output slot: load on completion, hold while stalled, empty on transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_strb_reg  <= '0;
         out_last_reg  <= 1'b0;
      end else if (complete) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= word_next;
         out_strb_reg  <= strb_next;
         out_last_reg  <= in_last;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Debug count of accepted saturating elements, sticky at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt_reg <= '0;
      end else if (accept && q_sat && (sat_cnt_reg != '1)) begin
         sat_cnt_reg <= sat_cnt_reg + SAT_CNT_W'(1);
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_strb  = out_strb_reg;
   assign out_last  = out_last_reg;
   assign sat_cnt   = sat_cnt_reg;

endmodule
